// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ write-domain requesters.
// One owner at a time for a burst; every transfer is qualified by the write-side full flag.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int MAXBURST = 8,
  parameter int CNTW     = 16
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*DATASIZE-1:0] din,
  input  logic                     full,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic                     busy,
  output logic [CNTW-1:0]          word_cnt
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [8:0] MAXB  = 9'(MAXBURST);

  logic [0:0]          state_reg, state_next;
  logic [NREQ-1:0]     gnt_reg, gnt_next;
  logic [7:0]          beat_reg, beat_next;
  logic [IDXW-1:0]     last_owner_reg, last_owner_next;
  logic [CNTW-1:0]     word_cnt_reg;

  logic [DATASIZE-1:0] lane [NREQ];
  logic [IDXW-1:0]     owner_idx;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_valid;
  logic [IDXW:0]       cand;
  logic                in_burst;
  logic                xfer;
  logic                hit_max;
  logic                end_burst;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi] = din[gi*DATASIZE +: DATASIZE];
    end
  endgenerate

  // gnt_reg is one-hot, so OR-ing the indices of set bits yields the owner.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_reg[IDXW'(i)]) owner_idx = owner_idx | IDXW'(i);
    end
  end

  // Walk from farthest to nearest so the requester closest after last_owner wins.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_owner_reg} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (req[cand[IDXW-1:0]]) begin
        pick_idx   = cand[IDXW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  assign in_burst  = (state_reg == BURST);
  assign xfer      = wrst_n & in_burst & req[owner_idx] & ~full;
  assign hit_max   = ({1'b0, beat_reg} + 9'd1) == MAXB;
  assign end_burst = (xfer & last[owner_idx]) | (xfer & hit_max) | ~req[owner_idx];

  assign winc     = xfer;
  assign ack      = xfer ? gnt_reg : '0;
  assign wdata    = in_burst ? lane[owner_idx] : '0;
  assign gnt      = gnt_reg;
  assign busy     = in_burst;
  assign word_cnt = word_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    beat_next       = beat_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BURST;
          gnt_next   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (end_burst) begin
          state_next      = IDLE;
          gnt_next        = '0;
          last_owner_next = owner_idx;
        end else if (xfer) begin
          beat_next = beat_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      beat_reg       <= '0;
      last_owner_reg <= IDXW'(NREQ-1);
      word_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      beat_reg       <= beat_next;
      last_owner_reg <= last_owner_next;
      if (winc) word_cnt_reg <= word_cnt_reg + CNTW'(1);
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO between NREQ write-domain requesters.
- Grants one requester at a time for a burst. Forwards its data to the FIFO write port (winc/wdata). Qualifies every transfer with the write-side full flag.
- Sits entirely in the wclk domain, directly in front of the write-pointer/full-flag logic and the FIFO memory write port.

Parameters:
- NREQ, 4: number of requesters (2..16).
- DATASIZE, 8: FIFO word width.
- MAXBURST, 8: maximum words per grant before forced re-arbitration (1..255).
- CNTW, 16: width of the accepted-word counter.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  reset; synchronous, active-low, sampled on rising wclk.
- req  input  NREQ  per-requester valid; bit i high = requester i has a word on its data lane.
- last  input  NREQ  per-requester end-of-burst marker, qualified by req[i].
- din  input  NREQ*DATASIZE  data lanes; lane i = din[i*DATASIZE +: DATASIZE].
- full  input  1  FIFO full flag from the write-pointer logic.
- gnt  output  NREQ  registered one-hot current owner; all-zero when idle.
- ack  output  NREQ  combinational; ack[i] = requester i's word is written this cycle.
- winc  output  1  combinational FIFO write enable.
- wdata  output  DATASIZE  combinational FIFO write data.
- busy  output  1  registered; high while in BURST.
- word_cnt  output  CNTW  registered count of words written; wraps modulo 2^CNTW.

Behaviour:
- Reset (wrst_n low at a rising edge) sets:
  - state = IDLE, gnt = 0, busy = 0, beat = 0, word_cnt = 0, last_owner = NREQ-1.
  - Requester 0 therefore has first priority.
- While wrst_n is low: winc = 0 and ack = 0 (gated combinationally).
- States:
  - IDLE: if req != 0, pick the first i with req[i]=1, searching from last_owner+1 upward modulo NREQ. Register gnt = onehot(i), busy = 1, beat = 0, and go to BURST. If req == 0, stay in IDLE.
  - BURST (owner o): xfer = req[o] & ~full. Then winc = xfer, ack[o] = xfer, wdata = lane o.
    - When xfer is low: wdata = lane o, value don't-care.
    - When not in BURST: winc = 0, ack = 0, wdata = 0.
- Burst termination is evaluated at each rising edge in BURST. Return to IDLE with gnt = 0, busy = 0, last_owner = o when any of these holds:
  - (a) xfer & last[o];
  - (b) xfer and beat+1 == MAXBURST;
  - (c) req[o] == 0 (requester abandons; no word written that cycle).
- Otherwise, beat increments on xfer.
- full high in BURST:
  - No write, no ack, beat frozen, grant held.
  - If req[o] drops while full is high, the burst ends per (c).
- Latency:
  - req rising in IDLE gives gnt on the next edge.
  - The first word can be written in the first BURST cycle.
  - One IDLE bubble cycle always separates consecutive bursts.
- Losing requesters simply wait. Their req may stay high without penalty. ack is the only acceptance indication.
- word_cnt increments by 1 on every edge where winc = 1. Wraps from 2^CNTW-1 to 0.
- Simultaneous full rise and last: no transfer, so the burst continues until the last word is actually written.
- Reset mid-burst: the next edge forces IDLE. The word presented on that edge is not written. last_owner returns to NREQ-1.
- MAXBURST = 1: every accepted word ends the burst.

Test Plan:
- Only req[0]=1, last on the 3rd word, full=0 → gnt=0001 one cycle after req; winc high 3 consecutive cycles with wdata = lane 0 values; gnt=0000 after the 3rd; word_cnt=3.
- req=1111 held, last=1111 → grants 0001,0010,0100,1000,0001 in order, each burst 1 word, one idle cycle between; word_cnt=4 after the first round.
- req[2] held with last=0, req[3]=1, MAXBURST=8 → exactly 8 acks to requester 2, then IDLE, then gnt=1000.
- Owner 1 mid-burst, full high 3 cycles → winc=0 and ack=0 for those 3 cycles, gnt stays 0010, beat unchanged; transfers resume the cycle full falls, total burst length unaffected.
- Owner 0 drops req after 2 words (no last) → next edge IDLE; word_cnt=2; next grant starts search at requester 1.
- wrst_n low for one edge during a burst → winc=0 that cycle, then gnt=0, busy=0, word_cnt=0; with req=1111, the following grant is 0001.
